decode_hazard_ctl: RTL

Pipeline hazard controller for the decode stage. It records the destination register of every instruction in flight through EX, MEM and WB. It stalls decode on read-after-write hazards against the 8-entry register file. When forwarding is compiled in, it also produces bypass selects for the two register-file read operands. It sits beside decode, consumes the already-muxed write register (the `w_reg` selected by `w_reg_cont`), and gates the ID/EX pipeline register.

---
 rtl/decode_hazard_ctl.sv | 98 +++++++++
 1 files changed

// File: rtl/decode_hazard_ctl.sv
// Decode-stage hazard controller: tracks EX/MEM/WB destinations, stalls on RAW hazards.
// Define DECODE_FWD_EN to build with operand bypass selects (only load-use then stalls).
module decode_hazard_ctl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [2:0]             id_rs,
  input  logic                   id_rs_use,
  input  logic [2:0]             id_rt,
  input  logic                   id_rt_use,
  input  logic                   id_wr_en,
  input  logic [2:0]             id_wr_reg,
  input  logic                   id_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   wb_reg_w_en,
  output logic [2:0]             wb_w_reg,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic       ex_valid, ex_wr, ex_load;
  logic [2:0] ex_reg;
  logic       mem_valid, mem_wr, mem_load;
  logic [2:0] mem_reg;
  logic       wb_valid, wb_wr, wb_load;
  logic [2:0] wb_reg;

  logic ex_hit_rs, mem_hit_rs, wb_hit_rs;
  logic ex_hit_rt, mem_hit_rt, wb_hit_rt;

  // The WB load bit only exists to keep every slot the same shape.
  logic unused_wb_load;
  assign unused_wb_load = wb_load;

  always_comb begin
    ex_hit_rs  = id_rs_use & ex_valid  & ex_wr  & (ex_reg  == id_rs);
    mem_hit_rs = id_rs_use & mem_valid & mem_wr & (mem_reg == id_rs);
    wb_hit_rs  = id_rs_use & wb_valid  & wb_wr  & (wb_reg  == id_rs);
    ex_hit_rt  = id_rt_use & ex_valid  & ex_wr  & (ex_reg  == id_rt);
    mem_hit_rt = id_rt_use & mem_valid & mem_wr & (mem_reg == id_rt);
    wb_hit_rt  = id_rt_use & wb_valid  & wb_wr  & (wb_reg  == id_rt);
  end

`ifdef DECODE_FWD_EN
  function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
    if (e)      return 2'b01;
    else if (m) return 2'b10;
    else if (w) return 2'b11;
    else        return 2'b00;
  endfunction

  always_comb begin
    stall = id_valid & ~flush & ex_load & (ex_hit_rs | ex_hit_rt);
    fwd_a = pick(ex_hit_rs, mem_hit_rs, wb_hit_rs);
    fwd_b = pick(ex_hit_rt, mem_hit_rt, wb_hit_rt);
  end
`else
  always_comb begin
    stall = id_valid & ~flush &
            (ex_hit_rs | mem_hit_rs | wb_hit_rs | ex_hit_rt | mem_hit_rt | wb_hit_rt);
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end
`endif

  assign wb_reg_w_en = wb_valid & wb_wr;
  assign wb_w_reg    = wb_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0; ex_wr  <= 1'b0; ex_reg  <= '0; ex_load  <= 1'b0;
      mem_valid <= 1'b0; mem_wr <= 1'b0; mem_reg <= '0; mem_load <= 1'b0;
      wb_valid  <= 1'b0; wb_wr  <= 1'b0; wb_reg  <= '0; wb_load  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wb_valid  <= mem_valid; wb_wr  <= mem_wr; wb_reg  <= mem_reg; wb_load  <= mem_load;
      mem_valid <= ex_valid;  mem_wr <= ex_wr;  mem_reg <= ex_reg;  mem_load <= ex_load;
      if (id_valid && !stall && !flush) begin
        ex_valid <= 1'b1;
        ex_wr    <= id_wr_en;
        ex_reg   <= id_wr_reg;
        ex_load  <= id_is_load;
      end else begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_reg   <= '0;
        ex_load  <= 1'b0;
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
